vga_in_decoder: RTL and testbench

VGA_IN_DECODER -- requirements
Module: vga_in_decoder

---
 rtl/vga_in_decoder.sv | 196 +++++++++++++++++++
 tb/tb_vga_in_decoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_in_decoder.sv
// VGA input decoder: measures line/frame timing, locks to the expected raster
// and emits active-area pixels with X/Y coordinates once locked.
module vga_in_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        ul1Clock,
  input  logic        ul1Reset_n,
  input  logic        ul1PixelEn,
  input  logic [7:0]  ul8Red,
  input  logic [7:0]  ul8Green,
  input  logic [7:0]  ul8Blue,
  input  logic        ul1Blank_n,
  input  logic        ul1HSync,
  input  logic        ul1VSync,
  output logic        ul1PixelValid,
  output logic [23:0] ul24Pixel,
  output logic [10:0] ul11X,
  output logic [9:0]  ul10Y,
  output logic        ul1FrameStart,
  output logic        ul1Locked,
  output logic        ul1TimingErr,
  output logic [11:0] ul12LineLen,
  output logic [10:0] ul11FrameLines
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  function automatic logic [11:0] inc_sat12(input logic [11:0] v);
    return (v == '1) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] inc_sat11(input logic [10:0] v);
    return (v == '1) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] inc_sat10(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

  // Reset asserts asynchronously; release is retimed so sampling resumes on
  // the second rising edge after ul1Reset_n goes high.
  logic rst_sync_n;
  always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
    if (!ul1Reset_n) rst_sync_n <= 1'b0;
    else             rst_sync_n <= 1'b1;
  end

  // ---- stage p0: input registers ----
  logic        vld_p0, hs_p0, vs_p0, blank_p0;
  logic [23:0] rgb_p0;

  always_ff @(posedge ul1Clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      vld_p0   <= 1'b0;
      hs_p0    <= 1'b0;
      vs_p0    <= 1'b0;
      blank_p0 <= 1'b0;
    end else begin
      vld_p0   <= ul1PixelEn;
      hs_p0    <= ul1HSync;
      vs_p0    <= ul1VSync;
      blank_p0 <= ul1Blank_n;
    end
  end

  always_ff @(posedge ul1Clock) begin
    rgb_p0 <= {ul8Red, ul8Green, ul8Blue};
  end

  // ---- stage p0 -> p1: edge detection, measurement and lock control ----
  logic        hs_prev, vs_prev, blank_prev;
  logic [11:0] line_cnt;
  logic [10:0] frame_cnt;
  logic        lines_ok, had_active;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  state_t      state_q, state_d;

  logic        hs_fall, vs_fall, blank_rise, blank_fall, active;
  logic        line_ok, frame_ok, bad_timing, err_d, out_en;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  assign hs_fall    = vld_p0 & hs_prev & ~hs_p0;
  assign vs_fall    = vld_p0 & vs_prev & ~vs_p0;
  assign blank_rise = vld_p0 & ~blank_prev & blank_p0;
  assign blank_fall = vld_p0 & blank_prev & ~blank_p0;
  assign active     = vld_p0 & blank_p0;

  assign pix_x = blank_rise ? 11'd0 : x_cnt;
  assign pix_y = vs_fall ? 10'd0 : y_cnt;

  // A line ending on the VSync fall still belongs to the frame being closed.
  assign line_ok    = (line_cnt == 12'(H_TOTAL));
  assign frame_ok   = lines_ok & (~hs_fall | line_ok) & (frame_cnt == 11'(V_TOTAL));
  assign bad_timing = (hs_fall & ~line_ok)
                    | (vs_fall & (frame_cnt != 11'(V_TOTAL)))
                    | (active & ((pix_x >= 11'(H_ACTIVE)) | (pix_y >= 10'(V_ACTIVE))));

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      SEARCH:  if (vs_fall) state_d = ACQUIRE;
      ACQUIRE: if (vs_fall && frame_ok) state_d = LOCKED;
      LOCKED: begin
        if (bad_timing) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end else begin
          out_en = active;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge ul1Clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      hs_prev        <= 1'b0;
      vs_prev        <= 1'b0;
      blank_prev     <= 1'b0;
      line_cnt       <= '0;
      frame_cnt      <= '0;
      lines_ok       <= 1'b0;
      had_active     <= 1'b0;
      x_cnt          <= '0;
      y_cnt          <= '0;
      ul12LineLen    <= '0;
      ul11FrameLines <= '0;
    end else if (vld_p0) begin
      hs_prev    <= hs_p0;
      vs_prev    <= vs_p0;
      blank_prev <= blank_p0;

      if (hs_fall) begin
        ul12LineLen <= line_cnt;
        line_cnt    <= 12'd1;
      end else begin
        line_cnt <= inc_sat12(line_cnt);
      end

      // VSync is handled first, so a coincident HSync fall opens line 1.
      if (vs_fall) begin
        ul11FrameLines <= frame_cnt;
        frame_cnt      <= hs_fall ? 11'd1 : 11'd0;
        lines_ok       <= 1'b1;
      end else if (hs_fall) begin
        frame_cnt <= inc_sat11(frame_cnt);
        if (!line_ok) lines_ok <= 1'b0;
      end

      if (active) x_cnt <= inc_sat11(pix_x);

      if (vs_fall) begin
        y_cnt      <= 10'd0;
        had_active <= active;
      end else if (blank_fall) begin
        if (had_active) y_cnt <= inc_sat10(y_cnt);
        had_active <= 1'b0;
      end else if (active) begin
        had_active <= 1'b1;
      end
    end
  end

  // ---- stage p1: output registers ----
  always_ff @(posedge ul1Clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q       <= SEARCH;
      ul1TimingErr  <= 1'b0;
      ul1PixelValid <= 1'b0;
      ul1FrameStart <= 1'b0;
      ul24Pixel     <= '0;
      ul11X         <= '0;
      ul10Y         <= '0;
    end else begin
      state_q       <= state_d;
      ul1TimingErr  <= err_d;
      ul1PixelValid <= out_en;
      ul1FrameStart <= out_en & (pix_x == 11'd0) & (pix_y == 10'd0);
      if (out_en) begin
        ul24Pixel <= rgb_p0;
        ul11X     <= pix_x;
        ul10Y     <= pix_y;
      end
    end
  end

  assign ul1Locked = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_in_decoder.sv
// Scoreboard bench for vga_in_decoder on a reduced 20x12 raster (12x8 active).
module tb_vga_in_decoder;

  localparam int HT = 20, VT = 12, HA = 12, VA = 8;

  logic        clk = 1'b0, rst_n = 1'b0, pen = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        blank_n = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic        valid, fstart, locked, terr;
  logic [23:0] pixel;
  logic [10:0] xo, flines;
  logic [9:0]  yo;
  logic [11:0] llen;

  vga_in_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .ul1Clock(clk), .ul1Reset_n(rst_n), .ul1PixelEn(pen),
    .ul8Red(red), .ul8Green(green), .ul8Blue(blue),
    .ul1Blank_n(blank_n), .ul1HSync(hsync), .ul1VSync(vsync),
    .ul1PixelValid(valid), .ul24Pixel(pixel), .ul11X(xo), .ul10Y(yo),
    .ul1FrameStart(fstart), .ul1Locked(locked), .ul1TimingErr(terr),
    .ul12LineLen(llen), .ul11FrameLines(flines)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    logic [10:0] x;
    logic [9:0]  y;
    logic        fs;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  int          n_pix, n_fs, n_terr, last_x, last_y;
  logic [11:0] terr_len;
  logic [23:0] seen_a5;
  bit          mon_en = 0, exp_locked = 0, gap_mode = 0, prev_vld = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid: got x=%0d y=%0d pix=%h, required no pixel", xo, yo, pixel);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (pixel !== e.pix || xo !== e.x || yo !== e.y || fstart !== e.fs || cyc != e.due) begin
            n_bad++;
            $display("FAIL pixel_out: got pix=%h x=%0d y=%0d fs=%b cyc=%0d, required pix=%h x=%0d y=%0d fs=%b cyc=%0d",
                     pixel, xo, yo, fstart, cyc, e.pix, e.x, e.y, e.fs, e.due);
          end
          n_pix++;
          last_x = int'(xo);
          last_y = int'(yo);
          if (fstart) n_fs++;
          if (xo == 11'd10 && yo == 10'd2) seen_a5 = pixel;
        end
        if (!locked) begin
          n_cmp++; n_bad++;
          $display("FAIL valid_unlocked: got locked=%b, required 1", locked);
        end
        if (gap_mode && prev_vld) begin
          n_cmp++; n_bad++;
          $display("FAIL consecutive_valid: got two valid cycles, required gaps");
        end
      end else begin
        if (q.size() > 0 && q[0].due < cyc) begin
          exp_t m;
          m = q.pop_front();
          n_cmp++; n_bad++;
          $display("FAIL missed_pixel: got none at cyc %0d, required x=%0d y=%0d", m.due, m.x, m.y);
        end
        if (fstart) begin
          n_cmp++; n_bad++;
          $display("FAIL framestart_alone: got 1 without valid, required 0");
        end
      end
      if (terr) begin
        n_terr++;
        terr_len = llen;
        if (locked) begin
          n_cmp++; n_bad++;
          $display("FAIL terr_locked: got locked=1 on error pulse, required 0");
        end
      end
      prev_vld = valid;
    end
  end

  task automatic drive_cycle(input bit en, input bit hs, input bit vs, input bit bl, input logic [23:0] rgb);
    @(posedge clk);
    #1;
    pen = en; hsync = hs; vsync = vs; blank_n = bl;
    {red, green, blue} = rgb;
  endtask

  task automatic do_reset();
    mon_en = 0;
    #2 rst_n = 1'b0;
    pen = 1'b0;
    repeat (3) @(posedge clk);
    q.delete();
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    n_pix = 0; n_fs = 0; n_terr = 0; last_x = -1; last_y = -1;
    terr_len = '0; seen_a5 = '0; exp_locked = 0; prev_vld = 0;
    mon_en = 1;
  endtask

  task automatic lead_in();
    for (int i = 0; i < 5; i++) drive_cycle(1, 1, 1, 0, 24'h0);
  endtask

  // Lines with v<2 carry VSync low, h<2 HSync low; active window v 2..9, h 4..15.
  task automatic drive_frame(input int lines, input int short_line, input int abort_line);
    for (int v = 0; v < lines; v++) begin
      int len;
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        logic [23:0] rgb;
        bit bl;
        if (v == abort_line && h == 8) return;
        if (short_line >= 0 && v == short_line + 1 && h == 0) exp_locked = 0;
        bl  = (v >= 2 && v < 2 + VA && h >= 4 && h < 4 + HA);
        rgb = 24'($urandom);
        if (bl && v == 4 && h == 14) rgb = 24'hA53CF0;
        drive_cycle(1, h >= 2, v >= 2, bl, rgb);
        if (bl && exp_locked) begin
          exp_t e;
          e.pix = rgb; e.x = 11'(h - 4); e.y = 10'(v - 2);
          e.fs = (h == 4 && v == 2); e.due = cyc + 2;
          q.push_back(e);
        end
        if (gap_mode) drive_cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
      end
    end
  endtask

  task automatic drain();
    repeat (4) drive_cycle(0, 1, 1, 0, 24'h0);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending pixels, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid, fstart, locked, terr} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b, required 0000", {valid, fstart, locked, terr});
    end
    n_cmp++;
    if (llen !== 12'd0 || flines !== 11'd0) begin
      n_bad++; $display("FAIL reset_meas: got len=%0d lines=%0d, required 0 0", llen, flines);
    end
    n_cmp++;
    if (pixel !== 24'd0 || xo !== 11'd0 || yo !== 10'd0) begin
      n_bad++; $display("FAIL reset_data: got pix=%h x=%0d y=%0d, required 0", pixel, xo, yo);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_standard_lock();
    do_reset();
    gap_mode = 0;
    lead_in();
    drive_frame(VT, -1, -1);
    n_cmp++;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %b, required 0", locked); end
    exp_locked = 1;
    drive_frame(VT, -1, -1);
    n_cmp++;
    if (locked !== 1'b1 || llen !== 12'(HT) || flines !== 11'(VT)) begin
      n_bad++; $display("FAIL lock_meas: got locked=%b len=%0d lines=%0d, required 1 %0d %0d", locked, llen, flines, HT, VT);
    end
    n_pix = 0; n_fs = 0; seen_a5 = '0;
    drive_frame(VT, -1, -1);
    drain();
    n_cmp++;
    if (n_pix != HA * VA || n_fs != 1) begin
      n_bad++; $display("FAIL frame_count: got pixels=%0d fs=%0d, required %0d 1", n_pix, n_fs, HA * VA);
    end
    n_cmp++;
    if (last_x != HA - 1 || last_y != VA - 1) begin
      n_bad++; $display("FAIL last_pixel: got x=%0d y=%0d, required %0d %0d", last_x, last_y, HA - 1, VA - 1);
    end
    n_cmp++;
    if (seen_a5 !== 24'hA53CF0) begin n_bad++; $display("FAIL pixel_a5: got %h, required a53cf0", seen_a5); end
    n_cmp++;
    if (n_terr != 0) begin n_bad++; $display("FAIL terr_spurious: got %0d, required 0", n_terr); end
  endtask

  task automatic test_half_rate();
    do_reset();
    gap_mode = 1;
    lead_in();
    drive_frame(VT, -1, -1);
    exp_locked = 1;
    drive_frame(VT, -1, -1);
    n_pix = 0; n_fs = 0;
    drive_frame(VT, -1, -1);
    drain();
    gap_mode = 0;
    n_cmp++;
    if (n_pix != HA * VA || n_fs != 1 || last_x != HA - 1 || last_y != VA - 1) begin
      n_bad++; $display("FAIL half_rate: got pixels=%0d fs=%0d last=%0d,%0d, required %0d 1 %0d,%0d",
                        n_pix, n_fs, last_x, last_y, HA * VA, HA - 1, VA - 1);
    end
    n_cmp++;
    if (llen !== 12'(HT) || flines !== 11'(VT)) begin
      n_bad++; $display("FAIL half_meas: got len=%0d lines=%0d, required %0d %0d", llen, flines, HT, VT);
    end
  endtask

  task automatic test_short_line();
    do_reset();
    lead_in();
    drive_frame(VT, -1, -1);
    exp_locked = 1;
    drive_frame(VT, -1, -1);
    drive_frame(VT, 5, -1);
    n_cmp++;
    if (n_terr != 1 || terr_len !== 12'(HT - 1)) begin
      n_bad++; $display("FAIL short_terr: got pulses=%0d len=%0d, required 1 %0d", n_terr, terr_len, HT - 1);
    end
    n_cmp++;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL short_unlock: got %b, required 0", locked); end
    drive_frame(VT, -1, -1);
    exp_locked = 1;
    n_pix = 0;
    drive_frame(VT, -1, -1);
    drain();
    n_cmp++;
    if (locked !== 1'b1 || n_pix != HA * VA || n_terr != 1) begin
      n_bad++; $display("FAIL relock: got locked=%b pixels=%0d pulses=%0d, required 1 %0d 1", locked, n_pix, n_terr, HA * VA);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    lead_in();
    drive_frame(VT, -1, -1);
    exp_locked = 1;
    drive_frame(VT, -1, 5);
    mon_en = 0;
    q.delete();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid, locked, fstart} !== 3'b0 || pixel !== 24'd0 || xo !== 11'd0 || yo !== 10'd0
        || llen !== 12'd0 || flines !== 11'd0) begin
      n_bad++; $display("FAIL midreset: got v=%b l=%b pix=%h x=%0d y=%0d len=%0d lines=%0d, required all 0",
                        valid, locked, pixel, xo, yo, llen, flines);
    end
    pen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_locked = 0; prev_vld = 0; n_pix = 0;
    mon_en = 1;
    lead_in();
    drive_frame(VT, -1, -1);
    exp_locked = 1;
    drive_frame(VT, -1, -1);
    drain();
    n_cmp++;
    if (n_pix != HA * VA || locked !== 1'b1) begin
      n_bad++; $display("FAIL reset_relock: got pixels=%0d locked=%b, required %0d 1", n_pix, locked, HA * VA);
    end
  endtask

  task automatic test_long_frame();
    do_reset();
    lead_in();
    drive_frame(VT + 1, -1, -1);
    drive_frame(VT + 1, -1, -1);
    drive_frame(VT, -1, -1);
    n_cmp++;
    if (flines !== 11'(VT + 1) || locked !== 1'b0 || n_terr != 0) begin
      n_bad++; $display("FAIL long_frame: got lines=%0d locked=%b pulses=%0d, required %0d 0 0", flines, locked, n_terr, VT + 1);
    end
    exp_locked = 1;
    n_pix = 0;
    drive_frame(VT, -1, -1);
    drain();
    n_cmp++;
    if (locked !== 1'b1 || n_pix != HA * VA) begin
      n_bad++; $display("FAIL long_recover: got locked=%b pixels=%0d, required 1 %0d", locked, n_pix, HA * VA);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_standard_lock();
    test_half_rate();
    test_short_line();
    test_reset_midframe();
    test_long_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
